// File: rtl/us_sample_mem_writer.sv
// Packs four 16-bit samples per 64-bit word and writes them to consecutive memory addresses as an Avalon-MM master.
// Latency: the write is on the bus in the cycle after the 4th (or eop) sample is taken; one word every 5 cycles.
// Backpressure: snk_ready drops while a write is pending; the write holds on avm_waitrequest until it commits.
module us_sample_mem_writer #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 64,
    parameter int SAMPLE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       num_words,
    input  logic                  snk_valid,
    input  logic [SAMPLE_W-1:0]   snk_data,
    input  logic                  snk_eop,
    output logic                  snk_ready,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       words_written
);

    localparam int BE_W    = DATA_W / 8;
    localparam int LANE_BE = BE_W / 4;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   remaining;
    logic [1:0]        lane;
    logic              eop_seen;

    // Byte enables covering lanes 0..last_lane; a full word gives all ones.
    function automatic logic [BE_W-1:0] be_mask(input logic [1:0] last_lane);
        logic [BE_W-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (int'(last_lane) >= i) begin
                m[i*LANE_BE +: LANE_BE] = '1;
            end
        end
        return m;
    endfunction

    // Capture FSM: all bus, stream and status outputs are registered here.
    // avm_writedata doubles as the pack register; it is zeroed between words
    // so lanes left unfilled by an early eop write as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            remaining      <= '0;
            lane           <= '0;
            eop_seen       <= 1'b0;
            snk_ready      <= 1'b0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            words_written  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        avm_address   <= base_addr;
                        remaining     <= num_words;
                        words_written <= '0;
                        lane          <= '0;
                        eop_seen      <= 1'b0;
                        avm_writedata <= '0;
                        busy          <= 1'b1;
                        if (num_words == '0) begin
                            state <= S_DONE;
                        end else begin
                            snk_ready <= 1'b1;
                            state     <= S_FILL;
                        end
                    end
                end

                S_FILL: begin
                    if (snk_valid && snk_ready) begin
                        avm_writedata[int'(lane)*SAMPLE_W +: SAMPLE_W] <= snk_data;
                        lane <= lane + 2'd1;
                        if (lane == 2'd3 || snk_eop) begin
                            eop_seen       <= snk_eop;
                            avm_byteenable <= be_mask(lane);
                            snk_ready      <= 1'b0;
                            avm_chipselect <= 1'b1;
                            avm_write      <= 1'b1;
                            state          <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    if (!avm_waitrequest) begin
                        avm_address    <= avm_address + ADDR_ONE;
                        remaining      <= remaining - CNT_ONE;
                        words_written  <= words_written + CNT_ONE;
                        avm_chipselect <= 1'b0;
                        avm_write      <= 1'b0;
                        avm_writedata  <= '0;
                        lane           <= '0;
                        if (remaining == CNT_ONE || eop_seen) begin
                            state <= S_DONE;
                        end else begin
                            snk_ready <= 1'b1;
                            state     <= S_FILL;
                        end
                    end
                end

                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_us_sample_mem_writer.sv
module tb_us_sample_mem_writer;

    localparam int ADDR_W = 13;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
        logic [7:0]        be;
    } wr_t;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_words;
    logic              snk_valid;
    logic [15:0]       snk_data;
    logic              snk_eop;
    logic              snk_ready;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [63:0]       avm_writedata;
    logic [7:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_written;

    int  n_assert   = 0;
    int  n_fail     = 0;
    int  done_count = 0;
    int  commits    = 0;
    int  stall_cycles = 0;
    int  exp_done   = 0;
    wr_t exp_q[$];
    wr_t held;
    bit  stalled    = 0;

    us_sample_mem_writer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .num_words       (num_words),
        .snk_valid       (snk_valid),
        .snk_data        (snk_data),
        .snk_eop         (snk_eop),
        .snk_ready       (snk_ready),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .words_written   (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: commits are popped from the scoreboard, stalled writes must hold steady.
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled = 0;
        end else begin
            check("cs_eq_write", avm_chipselect, avm_write);
            if (done) done_count++;
            if (avm_write) begin
                if (stalled)
                    check("stall_stable", {avm_address, avm_writedata, avm_byteenable}, held);
                if (avm_waitrequest) begin
                    stalled = 1;
                    held = '{avm_address, avm_writedata, avm_byteenable};
                    stall_cycles++;
                end else begin
                    stalled = 0;
                    commits++;
                    check("write_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("wr_addr", avm_address, e.addr);
                        check("wr_data", avm_writedata, e.data);
                        check("wr_be", avm_byteenable, e.be);
                    end
                end
            end else begin
                stalled = 0;
            end
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
        start = 1'b1; base_addr = b; num_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic eop);
        int n;
        n = 0;
        snk_valid = 1'b1; snk_data = d; snk_eop = eop;
        do begin
            @(negedge clk);
            n++;
        end while (!snk_ready && n < 100);
        check("sample_accept", snk_ready, 1'b1);
        @(posedge clk); #1;
        snk_valid = 1'b0; snk_eop = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] s0, input logic [ADDR_W-1:0] a);
        logic [15:0] s1, s2, s3;
        s1 = s0 + 16'd1; s2 = s0 + 16'd2; s3 = s0 + 16'd3;
        exp_q.push_back('{a, {s3, s2, s1, s0}, 8'hFF});
        send(s0, 1'b0); send(s1, 1'b0); send(s2, 1'b0); send(s3, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        check(tag, done, 1'b1);
        exp_done++;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_pulses"}, done_count, exp_done);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        snk_valid = 1'b0; snk_data = '0; snk_eop = 1'b0; avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {snk_ready, avm_address, avm_chipselect, avm_write, avm_writedata,
                              avm_byteenable, busy, done, words_written}, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: two full words, back to back samples
        do_start(13'h0010, 14'd2);
        check("t1_busy", busy, 1'b1);
        send_word(16'h0001, 13'h0010);
        check("t1_latency_write", avm_write, 1'b1);
        check("t1_ready_low", snk_ready, 1'b0);
        send_word(16'h0005, 13'h0011);
        wait_done("t1_done");
        check("t1_words", words_written, 14'd2);
        check("t1_busy_end", busy, 1'b0);

        // 2: first write stalled by waitrequest for 3 cycles
        stall_cycles = 0;
        avm_waitrequest = 1'b1;
        do_start(13'h0100, 14'd2);
        send_word(16'h1000, 13'h0100);
        repeat (3) @(posedge clk);
        #1;
        check("t2_words_stalled", words_written, 14'd0);
        avm_waitrequest = 1'b0;
        @(posedge clk); #1;
        check("t2_words_commit", words_written, 14'd1);
        check("t2_stall_cycles", stall_cycles, 3);
        send_word(16'h2000, 13'h0101);
        wait_done("t2_done");
        check("t2_words", words_written, 14'd2);

        // 3: address wrap at the top of memory
        do_start(13'h1FFF, 14'd2);
        send_word(16'hA000, 13'h1FFF);
        send_word(16'hA004, 13'h0000);
        wait_done("t3_done");
        check("t3_busy", busy, 1'b0);
        check("t3_words", words_written, 14'd2);

        // 4: early eop at lane 1
        do_start(13'h0200, 14'd4);
        exp_q.push_back('{13'h0200, 64'h0000_0000_0002_0001, 8'h0F});
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b1);
        wait_done("t4_done");
        check("t4_words", words_written, 14'd1);

        // 5a: zero-length capture
        begin
            int n;
            int c0;
            c0 = commits;
            start = 1'b1; base_addr = 13'h0555; num_words = 14'd0;
            @(posedge clk); #1;
            start = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 20);
            check("t5_done_delay", n, 2);
            exp_done++;
            repeat (2) @(posedge clk);
            #1;
            check("t5_pulses", done_count, exp_done);
            check("t5_no_write", commits, c0);
            check("t5_words", words_written, 14'd0);
        end

        // 5b: start while busy is ignored
        do_start(13'h0300, 14'd1);
        exp_q.push_back('{13'h0300, 64'h0033_0032_0031_0030, 8'hFF});
        send(16'h0030, 1'b0);
        send(16'h0031, 1'b0);
        do_start(13'h0050, 14'd0);
        check("t5_busy_kept", busy, 1'b1);
        send(16'h0032, 1'b0);
        send(16'h0033, 1'b0);
        wait_done("t5b_done");
        check("t5b_words", words_written, 14'd1);

        // 6: reset during a stalled write aborts without a clock
        avm_waitrequest = 1'b1;
        do_start(13'h0400, 14'd2);
        send_word(16'h4000, 13'h0400);
        check("t6_in_write", avm_write, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_async", {avm_write, avm_chipselect, busy, snk_ready}, 4'b0000);
        exp_q.delete();
        @(posedge clk); #1;
        avm_waitrequest = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("t6_idle", {busy, avm_write, words_written}, '0);
        do_start(13'h0020, 14'd1);
        send_word(16'h6000, 13'h0020);
        wait_done("t6_done");
        check("t6_words", words_written, 14'd1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
